// File: rtl/mem_io_responder.sv
// Byte-bus target for the CPU core: 128KB RAM, UART RX/TX FIFOs,
// free-running cycle counter with byte-wise snapshot, and a sticky
// program-stop flag.
//
// Ports:
//   clk_in, rst_in     clock, asynchronous active-low reset
//   bus_a/bus_wdata    address / write byte from the core
//   bus_wr             1=write, 0=read
//   bus_rdata          read byte, registered (latency 1)
//   cpu_rdy            ready to core; low stalls the core
//   rx_valid/rx_data   UART receiver byte in, rx_ready = RX FIFO has room
//   tx_valid/tx_data   TX FIFO head out, tx_ready = UART takes head
//   halted             sticky program-stop flag
module mem_io_responder #(
  parameter int unsigned RAM_AW   = 17,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted
);

  localparam int unsigned RX_PW = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW = $clog2(TX_DEPTH);
  localparam int unsigned RX_CW = RX_PW + 1;
  localparam int unsigned TX_CW = TX_PW + 1;

  logic [7:0]       ram    [2**RAM_AW];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];

  logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic [31:0]      cyc_cnt;
  logic [31:0]      snap;

  logic             io_sel_c;
  logic [2:0]       io_off_c;
  logic             rd_acc_c, wr_acc_c;
  logic             rx_push_c, rx_pop_c;
  logic             tx_push_c, tx_pop_c;
  logic [7:0]       tx_push_data_c;
  logic [7:0]       io_rdata_c;
  logic [7:0]       rd_data_c;
  logic             unused_bus_c;

  // Address bits above the decoded window carry no meaning here
  assign unused_bus_c = ^bus_a[31:18];

  // Decode and handshakes; the bus is only sampled while cpu_rdy is high
  assign io_sel_c  = (bus_a[17:16] == 2'b11);
  assign io_off_c  = bus_a[2:0];
  assign rd_acc_c  = cpu_rdy && !bus_wr;
  assign wr_acc_c  = cpu_rdy && bus_wr;

  assign rx_ready  = (rx_count < RX_CW'(RX_DEPTH));
  assign rx_push_c = rx_valid && rx_ready;
  assign rx_pop_c  = rd_acc_c && io_sel_c && (io_off_c == 3'd0) && (rx_count != '0);

  // Offset 0 writes skip zero bytes; offset 4 (stop) always queues a zero
  assign tx_push_c = wr_acc_c && io_sel_c &&
                     (((io_off_c == 3'd0) && (bus_wdata != 8'h00)) || (io_off_c == 3'd4));
  assign tx_push_data_c = (io_off_c == 3'd4) ? 8'h00 : bus_wdata;
  assign tx_valid  = (tx_count != '0);
  assign tx_data   = tx_mem[tx_rd_ptr];
  assign tx_pop_c  = tx_valid && tx_ready;

  assign cpu_rdy   = !halted && (tx_count < TX_CW'(TX_DEPTH));

  // I/O read mux; an empty RX FIFO reads as zero (no bypass of a same-cycle push)
  always_comb begin
    io_rdata_c = 8'h00;
    case (io_off_c)
      3'd0:    io_rdata_c = (rx_count != '0) ? rx_mem[rx_rd_ptr] : 8'h00;
      3'd4:    io_rdata_c = cyc_cnt[7:0];
      3'd5:    io_rdata_c = snap[15:8];
      3'd6:    io_rdata_c = snap[23:16];
      3'd7:    io_rdata_c = snap[31:24];
      default: io_rdata_c = 8'h00;
    endcase
  end

  assign rd_data_c = io_sel_c ? io_rdata_c : ram[bus_a[RAM_AW-1:0]];

  // RAM and FIFO storage arrays (contents not reset)
  always_ff @(posedge clk_in) begin
    if (wr_acc_c && !io_sel_c) ram[bus_a[RAM_AW-1:0]] <= bus_wdata;
    if (rx_push_c) rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push_c) tx_mem[tx_wr_ptr] <= tx_push_data_c;
  end

  // Read data, counter, snapshot and stop flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus_rdata <= 8'h00;
      cyc_cnt   <= 32'd0;
      snap      <= 32'd0;
      halted    <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (rd_acc_c) bus_rdata <= rd_data_c;
      if (rd_acc_c && io_sel_c && (io_off_c == 3'd4)) snap <= cyc_cnt;
      if (wr_acc_c && io_sel_c && (io_off_c == 3'd4)) halted <= 1'b1;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
      if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
      case ({rx_push_c, rx_pop_c})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
      if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
      case ({tx_push_c, tx_pop_c})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

endmodule
